// File: rtl/idu1_sb_issue.sv
// Decode-to-execute issue stage: regfile read with writeback bypass, 1-bit-per-register
// scoreboard for RAW/WAW hazards, and a single valid/ready issue register toward the FUs.
module idu1_sb_issue #(
  parameter int             XLEN      = 32,
  parameter int             NREGS     = 32,
  parameter int             NUM_WB    = 2,
  parameter int             NUM_FU    = 4,
  parameter int             PAYLOAD_W = 64,
  parameter logic [XLEN-1:0] SP_INIT  = 32'h80000000,
  localparam int            AW        = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  logic                   dec_rs1_en,
  input  logic [AW-1:0]          dec_rs1_addr,
  input  logic                   dec_rs2_en,
  input  logic [AW-1:0]          dec_rs2_addr,
  input  logic                   dec_rd_en,
  input  logic [AW-1:0]          dec_rd_addr,
  input  logic [NUM_FU-1:0]      dec_fu_sel,
  input  logic [PAYLOAD_W-1:0]   dec_payload,
  output logic                   iss_valid,
  input  logic [NUM_FU-1:0]      iss_fu_ready,
  output logic [NUM_FU-1:0]      iss_fu_sel,
  output logic [XLEN-1:0]        iss_rs1_data,
  output logic [XLEN-1:0]        iss_rs2_data,
  output logic                   iss_rd_en,
  output logic [AW-1:0]          iss_rd_addr,
  output logic [PAYLOAD_W-1:0]   iss_payload,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*AW-1:0]   wb_addr,
  input  logic [NUM_WB*XLEN-1:0] wb_data,
  output logic [31:0]            stall_cnt
);

  logic [XLEN-1:0]      regs_q [NREGS];
  logic [XLEN-1:0]      regs_d [NREGS];
  logic [NREGS-1:0]     pend_q, pend_d;
  logic                 iss_valid_q, iss_valid_d;
  logic [NUM_FU-1:0]    iss_fu_sel_q, iss_fu_sel_d;
  logic [XLEN-1:0]      iss_rs1_data_q, iss_rs1_data_d;
  logic [XLEN-1:0]      iss_rs2_data_q, iss_rs2_data_d;
  logic                 iss_rd_en_q, iss_rd_en_d;
  logic [AW-1:0]        iss_rd_addr_q, iss_rd_addr_d;
  logic [PAYLOAD_W-1:0] iss_payload_q, iss_payload_d;
  logic [31:0]          stall_cnt_q, stall_cnt_d;

  logic [AW-1:0]   wb_a [NUM_WB];
  logic [XLEN-1:0] wb_d [NUM_WB];
  logic            hit1, hit2, hitd;
  logic [XLEN-1:0] byp1, byp2, rs1_val, rs2_val;
  logic            hazard, iss_fire, accept, eff_rd_en;

  // Port loop runs upward so the highest matching writeback port wins.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    hitd = 1'b0;
    byp1 = '0;
    byp2 = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      wb_a[i] = wb_addr[i*AW +: AW];
      wb_d[i] = wb_data[i*XLEN +: XLEN];
      if (wb_valid[i] && wb_a[i] == dec_rs1_addr) begin
        hit1 = 1'b1;
        byp1 = wb_d[i];
      end
      if (wb_valid[i] && wb_a[i] == dec_rs2_addr) begin
        hit2 = 1'b1;
        byp2 = wb_d[i];
      end
      if (wb_valid[i] && wb_a[i] == dec_rd_addr) hitd = 1'b1;
    end
  end

  always_comb begin
    rs1_val   = (dec_rs1_addr == '0) ? '0 : (hit1 ? byp1 : regs_q[dec_rs1_addr]);
    rs2_val   = (dec_rs2_addr == '0) ? '0 : (hit2 ? byp2 : regs_q[dec_rs2_addr]);
    hazard    = (dec_rs1_en & pend_q[dec_rs1_addr] & ~hit1)
              | (dec_rs2_en & pend_q[dec_rs2_addr] & ~hit2)
              | (dec_rd_en & (dec_rd_addr != '0) & pend_q[dec_rd_addr] & ~hitd);
    iss_fire  = iss_valid_q & ((|(iss_fu_sel_q & iss_fu_ready)) | (iss_fu_sel_q == '0));
    dec_ready = ~rst & ~flush & (~iss_valid_q | iss_fire) & ~hazard;
    accept    = dec_valid & dec_ready;
    eff_rd_en = dec_rd_en & (|dec_fu_sel) & (dec_rd_addr != '0);
  end

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i]) begin
        if (wb_a[i] != '0) regs_d[wb_a[i]] = wb_d[i];
        pend_d[wb_a[i]] = 1'b0;
      end
    end
    // An unissued instruction dropped by flush will never write back its rd.
    if (flush && iss_valid_q && iss_rd_en_q) pend_d[iss_rd_addr_q] = 1'b0;
    if (accept && eff_rd_en) pend_d[dec_rd_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    iss_valid_d    = iss_valid_q;
    iss_fu_sel_d   = iss_fu_sel_q;
    iss_rs1_data_d = iss_rs1_data_q;
    iss_rs2_data_d = iss_rs2_data_q;
    iss_rd_en_d    = iss_rd_en_q;
    iss_rd_addr_d  = iss_rd_addr_q;
    iss_payload_d  = iss_payload_q;
    if (flush) begin
      iss_valid_d = 1'b0;
    end else if (accept) begin
      iss_valid_d    = 1'b1;
      iss_fu_sel_d   = dec_fu_sel;
      iss_rs1_data_d = rs1_val;
      iss_rs2_data_d = rs2_val;
      iss_rd_en_d    = eff_rd_en;
      iss_rd_addr_d  = dec_rd_addr;
      iss_payload_d  = dec_payload;
    end else if (iss_fire) begin
      iss_valid_d = 1'b0;
    end
    stall_cnt_d = stall_cnt_q;
    if (dec_valid && hazard && !flush && stall_cnt_q != 32'hFFFFFFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= (r == 2) ? SP_INIT : '0;
      pend_q         <= '0;
      iss_valid_q    <= 1'b0;
      iss_fu_sel_q   <= '0;
      iss_rs1_data_q <= '0;
      iss_rs2_data_q <= '0;
      iss_rd_en_q    <= 1'b0;
      iss_rd_addr_q  <= '0;
      iss_payload_q  <= '0;
      stall_cnt_q    <= '0;
    end else begin
      regs_q         <= regs_d;
      pend_q         <= pend_d;
      iss_valid_q    <= iss_valid_d;
      iss_fu_sel_q   <= iss_fu_sel_d;
      iss_rs1_data_q <= iss_rs1_data_d;
      iss_rs2_data_q <= iss_rs2_data_d;
      iss_rd_en_q    <= iss_rd_en_d;
      iss_rd_addr_q  <= iss_rd_addr_d;
      iss_payload_q  <= iss_payload_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign iss_valid    = iss_valid_q;
  assign iss_fu_sel   = iss_fu_sel_q;
  assign iss_rs1_data = iss_rs1_data_q;
  assign iss_rs2_data = iss_rs2_data_q;
  assign iss_rd_en    = iss_rd_en_q;
  assign iss_rd_addr  = iss_rd_addr_q;
  assign iss_payload  = iss_payload_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_idu1_sb_issue.sv
// Bench for idu1_sb_issue: directed scenarios plus randomized traffic against a
// reference model of the register file, pending set and one-slot issue register.
module tb_idu1_sb_issue;
  localparam int XLEN = 32, NREGS = 32, NUM_WB = 2, NUM_FU = 4, PAYLOAD_W = 64, AW = 5;

  logic clk, rst, flush, dec_valid, dec_ready;
  logic dec_rs1_en, dec_rs2_en, dec_rd_en;
  logic [AW-1:0] dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic [NUM_FU-1:0] dec_fu_sel, iss_fu_ready, iss_fu_sel;
  logic [PAYLOAD_W-1:0] dec_payload, iss_payload;
  logic iss_valid, iss_rd_en;
  logic [XLEN-1:0] iss_rs1_data, iss_rs2_data;
  logic [AW-1:0] iss_rd_addr;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB*AW-1:0] wb_addr;
  logic [NUM_WB*XLEN-1:0] wb_data;
  logic [31:0] stall_cnt;

  int checks = 0, errors = 0;

  // Reference model state
  logic [XLEN-1:0] m_regs [NREGS];
  bit m_pend [NREGS];
  bit m_iv, m_rd_en, m_rs1_en, m_rs2_en, m_ready, obs_ready;
  logic [NUM_FU-1:0] m_fu;
  logic [XLEN-1:0] m_rs1, m_rs2;
  logic [AW-1:0] m_rd;
  logic [PAYLOAD_W-1:0] m_pl;
  logic [31:0] m_stall;

  idu1_sb_issue #(.XLEN(XLEN), .NREGS(NREGS), .NUM_WB(NUM_WB), .NUM_FU(NUM_FU),
                  .PAYLOAD_W(PAYLOAD_W), .SP_INIT(32'h80000000)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1_en(dec_rs1_en), .dec_rs1_addr(dec_rs1_addr),
    .dec_rs2_en(dec_rs2_en), .dec_rs2_addr(dec_rs2_addr),
    .dec_rd_en(dec_rd_en), .dec_rd_addr(dec_rd_addr),
    .dec_fu_sel(dec_fu_sel), .dec_payload(dec_payload),
    .iss_valid(iss_valid), .iss_fu_ready(iss_fu_ready), .iss_fu_sel(iss_fu_sel),
    .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data),
    .iss_rd_en(iss_rd_en), .iss_rd_addr(iss_rd_addr), .iss_payload(iss_payload),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .stall_cnt(stall_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: sample dec_ready and step the model mid-cycle, return 1 after the edge.
  task automatic cyc();
    bit hit [NREGS];
    logic [XLEN-1:0] hd [NREGS];
    logic [AW-1:0] a;
    bit haz, fire, acc, eff;
    @(negedge clk);
    obs_ready = dec_ready;
    for (int r = 0; r < NREGS; r++) begin hit[r] = 0; hd[r] = '0; end
    for (int i = 0; i < NUM_WB; i++) if (wb_valid[i]) begin
      a = wb_addr[i*AW +: AW];
      hit[a] = 1;
      hd[a] = wb_data[i*XLEN +: XLEN];
    end
    if (wb_valid == 2'b11) begin
      checks++;
      if (wb_addr[0 +: AW] == wb_addr[AW +: AW]) begin
        errors++; $display("FAIL wb_unique: both ports target x%0d", wb_addr[0 +: AW]);
      end
    end
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin m_regs[r] = (r == 2) ? 32'h80000000 : '0; m_pend[r] = 0; end
      m_iv = 0; m_fu = '0; m_rs1 = '0; m_rs2 = '0; m_rd_en = 0; m_rd = '0; m_pl = '0;
      m_stall = '0; m_ready = 0;
    end else begin
      haz = (dec_rs1_en && m_pend[dec_rs1_addr] && !hit[dec_rs1_addr]) ||
            (dec_rs2_en && m_pend[dec_rs2_addr] && !hit[dec_rs2_addr]) ||
            (dec_rd_en && dec_rd_addr != 0 && m_pend[dec_rd_addr] && !hit[dec_rd_addr]);
      fire = m_iv && ((m_fu & iss_fu_ready) != 0 || m_fu == 0);
      m_ready = !flush && (!m_iv || fire) && !haz;
      acc = dec_valid && m_ready;
      eff = dec_rd_en && dec_fu_sel != 0 && dec_rd_addr != 0;
      if (dec_valid && haz && !flush && m_stall != 32'hFFFFFFFF) m_stall++;
      for (int r = 0; r < NREGS; r++) if (hit[r]) m_pend[r] = 0;
      if (flush && m_iv && m_rd_en) m_pend[m_rd] = 0;
      if (acc && eff) m_pend[dec_rd_addr] = 1;
      if (flush) m_iv = 0;
      else if (acc) begin
        m_iv = 1; m_fu = dec_fu_sel; m_rd_en = eff; m_rd = dec_rd_addr; m_pl = dec_payload;
        m_rs1_en = dec_rs1_en; m_rs2_en = dec_rs2_en;
        m_rs1 = (dec_rs1_addr == 0) ? '0 : hit[dec_rs1_addr] ? hd[dec_rs1_addr] : m_regs[dec_rs1_addr];
        m_rs2 = (dec_rs2_addr == 0) ? '0 : hit[dec_rs2_addr] ? hd[dec_rs2_addr] : m_regs[dec_rs2_addr];
      end else if (fire) m_iv = 0;
      for (int r = 1; r < NREGS; r++) if (hit[r]) m_regs[r] = hd[r];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit e1, input int a1, input bit e2, input int a2,
                       input bit ed, input int ad, input logic [3:0] fu, input logic [63:0] pl);
    dec_valid = v; dec_rs1_en = e1; dec_rs1_addr = a1[AW-1:0];
    dec_rs2_en = e2; dec_rs2_addr = a2[AW-1:0];
    dec_rd_en = ed; dec_rd_addr = ad[AW-1:0]; dec_fu_sel = fu; dec_payload = pl;
  endtask

  task automatic set_wb(input int p, input int a, input logic [XLEN-1:0] d);
    wb_valid[p] = 1'b1; wb_addr[p*AW +: AW] = a[AW-1:0]; wb_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic idle();
    dec_valid = 0; wb_valid = '0; flush = 0;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; wb_valid = '0; wb_addr = '0; wb_data = '0; iss_fu_ready = 4'hF;
    drive(1, 1, 2, 0, 0, 0, 0, 4'b0001, 64'h0);
    cyc(); cyc();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", obs_ready); end
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid: got %b exp 0", iss_valid); end
    checks++; if ({iss_fu_sel, iss_rs1_data, iss_rs2_data, iss_rd_en, iss_rd_addr, iss_payload} !== '0) begin
      errors++; $display("FAIL reset_iss_fields: got nonzero, exp all zero"); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d exp 0", stall_cnt); end
    rst = 0;
    cyc();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL x2_ready: got %b exp 1", obs_ready); end
    checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL x2_iss_valid: got %b exp 1", iss_valid); end
    checks++; if (iss_rs1_data !== 32'h80000000) begin errors++; $display("FAIL x2_data: got %h exp 80000000", iss_rs1_data); end
    idle(); cyc();
  endtask

  task automatic test_raw();
    logic [31:0] s0;
    s0 = stall_cnt;
    drive(1, 0, 0, 0, 0, 1, 5, 4'b0001, 64'h5);
    cyc();
    drive(1, 1, 5, 0, 0, 0, 0, 4'b0001, 64'h6);
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL raw_stall%0d: got ready %b exp 0", k, obs_ready); end
    end
    set_wb(0, 5, 32'h1234);
    cyc();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL raw_release: got ready %b exp 1", obs_ready); end
    checks++; if (iss_rs1_data !== 32'h1234) begin errors++; $display("FAIL raw_bypass: got %h exp 1234", iss_rs1_data); end
    checks++; if (stall_cnt !== s0 + 32'd3) begin errors++; $display("FAIL raw_stall_cnt: got %0d exp %0d", stall_cnt, s0 + 3); end
    idle(); cyc();
  endtask

  task automatic test_waw();
    drive(1, 0, 0, 0, 0, 1, 7, 4'b0010, 64'h70);
    cyc();
    drive(1, 0, 0, 0, 0, 1, 7, 4'b0010, 64'h71);
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL waw_stall%0d: got ready %b exp 0", k, obs_ready); end
    end
    set_wb(1, 7, 32'hAAAA);
    cyc();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL waw_release: got ready %b exp 1", obs_ready); end
    wb_valid = '0;
    drive(1, 1, 7, 0, 0, 0, 0, 4'b0001, 64'h72);
    cyc();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL waw_repend: got ready %b exp 0", obs_ready); end
    set_wb(0, 7, 32'hBBBB);
    cyc();
    checks++; if (obs_ready !== 1'b1 || iss_rs1_data !== 32'hBBBB) begin
      errors++; $display("FAIL waw_second_wb: got ready %b data %h exp 1 bbbb", obs_ready, iss_rs1_data); end
    idle(); cyc();
  endtask

  task automatic test_fu_backpressure();
    logic [63:0] pa, pb;
    pa = {$urandom, $urandom}; pb = {$urandom, $urandom};
    iss_fu_ready = 4'b1011;
    drive(1, 1, 2, 0, 0, 0, 0, 4'b0100, pa);
    cyc();
    drive(1, 0, 0, 0, 0, 0, 0, 4'b0001, pb);
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b exp 0", k, obs_ready); end
      checks++; if (iss_valid !== 1'b1 || iss_fu_sel !== 4'b0100 || iss_payload !== pa || iss_rs1_data !== 32'h80000000) begin
        errors++; $display("FAIL bp_hold%0d: got v%b fu%b pl%h d%h exp v1 fu0100 pl%h d80000000",
                           k, iss_valid, iss_fu_sel, iss_payload, iss_rs1_data, pa); end
    end
    iss_fu_ready = 4'hF;
    cyc();
    checks++; if (obs_ready !== 1'b1 || iss_payload !== pb) begin
      errors++; $display("FAIL bp_release: got ready %b pl %h exp 1 %h", obs_ready, iss_payload, pb); end
    idle(); cyc();
  endtask

  task automatic test_flush();
    logic [31:0] s0;
    iss_fu_ready = 4'h0;
    drive(1, 0, 0, 0, 0, 1, 9, 4'b0001, 64'h90);
    cyc();
    idle(); cyc();
    s0 = stall_cnt;
    flush = 1;
    drive(1, 1, 9, 0, 0, 0, 0, 4'b0001, 64'h91);
    cyc();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b exp 0", obs_ready); end
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL flush_iss_valid: got %b exp 0", iss_valid); end
    checks++; if (stall_cnt !== s0) begin errors++; $display("FAIL flush_stall_cnt: got %0d exp %0d", stall_cnt, s0); end
    flush = 0;
    cyc();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL flush_pend_clear: got ready %b exp 1", obs_ready); end
    checks++; if (iss_rs1_data !== m_regs[9]) begin errors++; $display("FAIL flush_reader_data: got %h exp %h", iss_rs1_data, m_regs[9]); end
    iss_fu_ready = 4'hF;
    idle(); cyc();
  endtask

  task automatic test_x0_nop();
    set_wb(0, 0, 32'hFFFF);
    drive(1, 1, 0, 1, 0, 1, 0, 4'b0001, 64'h0);
    cyc();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b exp 1", obs_ready); end
    checks++; if (iss_rs1_data !== 32'h0 || iss_rs2_data !== 32'h0 || iss_rd_en !== 1'b0) begin
      errors++; $display("FAIL x0_read: got %h %h rd_en %b exp 0 0 0", iss_rs1_data, iss_rs2_data, iss_rd_en); end
    idle();
    drive(1, 1, 0, 0, 0, 0, 0, 4'b0001, 64'h1);
    cyc();
    checks++; if (obs_ready !== 1'b1 || iss_rs1_data !== 32'h0) begin
      errors++; $display("FAIL x0_after_wb: got ready %b data %h exp 1 0", obs_ready, iss_rs1_data); end
    idle(); cyc();
    iss_fu_ready = 4'h0;
    drive(1, 0, 0, 0, 0, 1, 3, 4'b0000, 64'hC0);
    cyc();
    checks++; if (iss_valid !== 1'b1 || iss_rd_en !== 1'b0) begin
      errors++; $display("FAIL nop_accept: got v%b rd_en%b exp v1 rd_en0", iss_valid, iss_rd_en); end
    drive(1, 1, 3, 0, 0, 0, 0, 4'b0001, 64'hC1);
    cyc();
    checks++; if (obs_ready !== 1'b1 || iss_payload !== 64'hC1) begin
      errors++; $display("FAIL nop_fires: got ready %b pl %h exp 1 c1", obs_ready, iss_payload); end
    iss_fu_ready = 4'hF;
    idle(); cyc();
  endtask

  task automatic test_random();
    logic [3:0] fus [5];
    int a0, a1;
    fus[0] = 4'b0000; fus[1] = 4'b0001; fus[2] = 4'b0010; fus[3] = 4'b0100; fus[4] = 4'b1000;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            fus[$urandom_range(0, 4)], {$urandom, $urandom});
      iss_fu_ready = 4'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      wb_valid = '0;
      a0 = $urandom_range(0, 7); a1 = $urandom_range(0, 7);
      if ($urandom_range(0, 2) == 0) set_wb(0, a0, $urandom);
      if ($urandom_range(0, 2) == 0 && a1 != a0) set_wb(1, a1, $urandom);
      cyc();
      checks++; if (obs_ready !== m_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b exp %b", n, obs_ready, m_ready); end
      checks++; if (iss_valid !== m_iv) begin errors++; $display("FAIL rnd_iss_valid[%0d]: got %b exp %b", n, iss_valid, m_iv); end
      if (m_iv) begin
        checks++; if ({iss_fu_sel, iss_rd_en, iss_rd_addr, iss_payload} !== {m_fu, m_rd_en, m_rd, m_pl}) begin
          errors++; $display("FAIL rnd_ctrl[%0d]: got fu%b rd%b/%0d pl%h exp fu%b rd%b/%0d pl%h", n,
                             iss_fu_sel, iss_rd_en, iss_rd_addr, iss_payload, m_fu, m_rd_en, m_rd, m_pl); end
        if (m_rs1_en) begin
          checks++; if (iss_rs1_data !== m_rs1) begin errors++; $display("FAIL rnd_rs1[%0d]: got %h exp %h", n, iss_rs1_data, m_rs1); end
        end
        if (m_rs2_en) begin
          checks++; if (iss_rs2_data !== m_rs2) begin errors++; $display("FAIL rnd_rs2[%0d]: got %h exp %h", n, iss_rs2_data, m_rs2); end
        end
      end
      checks++; if (stall_cnt !== m_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d exp %0d", n, stall_cnt, m_stall); end
    end
    idle(); cyc();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_fu_backpressure();
    test_flush();
    test_x0_nop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
